// File: rtl/cpu_pkg.sv
// Shared ISA constants and fetch-state encoding for the core front end.
package cpu_pkg;

  // Instruction field positions: fun[15:12] rd[11:9] rt[8:6] rs[5:3] op[2:0], jaddr[15:3]
  localparam int OPC_W     = 3;
  localparam int FUN_MSB   = 15;
  localparam int FUN_LSB   = 12;
  localparam int RD_MSB    = 11;
  localparam int RD_LSB    = 9;
  localparam int RT_MSB    = 8;
  localparam int RT_LSB    = 6;
  localparam int RS_MSB    = 5;
  localparam int RS_LSB    = 3;
  localparam int OP_MSB    = 2;
  localparam int OP_LSB    = 0;
  localparam int JADDR_MSB = 15;
  localparam int JADDR_LSB = 3;

  localparam logic [OPC_W-1:0] JUMP_OPC = 3'b011;

  // Byte distance between consecutive instruction words
  localparam logic [15:0] PC_STEP = 16'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Absolute jump target: word address from jaddr, always in the lower 32 KB
  function automatic logic [15:0] jump_target(input logic [15:0] instr);
    return {1'b0, instr[JADDR_MSB:JADDR_LSB], 2'b00};
  endfunction

  // Force a byte address onto a word boundary
  function automatic logic [15:0] word_align(input logic [15:0] addr);
    return {addr[15:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Combinational next-PC priority mux: redirect > stall > jump > sequential.
// Also flags a self-jump halt request and a misaligned redirect target.
module next_pc_sel
  import cpu_pkg::*;
#(
  parameter logic [2:0] JUMP_OP      = cpu_pkg::JUMP_OPC,
  parameter bit         HALT_ON_SELF = 1'b1
) (
  input  fetch_state_e state,
  input  logic [15:0]  pc,
  input  logic [15:0]  instr,
  input  logic         stall,
  input  logic         redirect,
  input  logic [15:0]  redirect_pc,
  output logic [15:0]  next_pc,
  output logic         halt_req,
  output logic         misalign
);

  // Select the next PC by state and event priority; BOOT always holds
  always_comb begin
    next_pc  = pc;
    halt_req = 1'b0;
    misalign = 1'b0;
    case (state)
      RUN: begin
        if (redirect) begin
          next_pc  = word_align(redirect_pc);
          misalign = |redirect_pc[1:0];
        end else if (stall) begin
          next_pc = pc;
        end else if (instr[OP_MSB:OP_LSB] == JUMP_OP) begin
          if (HALT_ON_SELF && (jump_target(instr) == pc)) begin
            halt_req = 1'b1;
          end else begin
            next_pc = jump_target(instr);
          end
        end else begin
          next_pc = pc + PC_STEP;
        end
      end
      HALT: begin
        if (redirect) begin
          next_pc  = word_align(redirect_pc);
          misalign = |redirect_pc[1:0];
        end
      end
      default: begin
        next_pc = pc;
      end
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer in front of a combinational instruction
// memory. Holds PC, the BOOT/RUN/HALT FSM, sticky error and fetch counter.
//
// Handshake: valid_o qualifies instr_o/pc_o for one cycle; there is no ready.
// Back-pressure is stall_i (holds PC, drops valid_o); redirect_i squashes the
// current fetch and always takes effect, even together with stall_i.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC          = 16'h0000,
  parameter int          IMEM_WORDS        = 1024,
  parameter logic [2:0]  JUMP_OPC          = cpu_pkg::JUMP_OPC,
  parameter int          HALT_ON_SELF_JUMP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  imem_rd_i,
  output logic [15:0]  imem_addr_o,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [15:0]  redirect_pc_i,
  output logic [15:0]  instr_o,
  output logic [15:0]  pc_o,
  output logic [15:0]  pc_plus4_o,
  output logic         valid_o,
  output logic         halt_o,
  output logic         err_o,
  output logic [15:0]  fetch_cnt_o,
  output fetch_state_e state_o
);

  localparam logic [31:0] IMEM_LIMIT = IMEM_WORDS;

  fetch_state_e state, state_nxt;
  logic [15:0]  pc, next_pc;
  logic [15:0]  fetch_cnt;
  logic         err;
  logic         halt_req;
  logic         misalign;
  logic         out_of_range;
  logic         valid;

  next_pc_sel #(
    .JUMP_OP      (JUMP_OPC),
    .HALT_ON_SELF (HALT_ON_SELF_JUMP != 0)
  ) u_next_pc_sel (
    .state       (state),
    .pc          (pc),
    .instr       (imem_rd_i),
    .stall       (stall_i),
    .redirect    (redirect_i),
    .redirect_pc (redirect_pc_i),
    .next_pc     (next_pc),
    .halt_req    (halt_req),
    .misalign    (misalign)
  );

  // A fetch is real only in RUN, not stalled and not squashed by a redirect
  assign valid        = (state == RUN) && !stall_i && !redirect_i;
  assign out_of_range = (state == RUN) && ({18'd0, pc[15:2]} >= IMEM_LIMIT);

  // Next-state logic: BOOT lasts one cycle, HALT leaves only on redirect
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (halt_req) state_nxt = HALT;
      HALT:    if (redirect_i) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // State, PC and sticky error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= next_pc;
      err   <= err | misalign | out_of_range;
    end
  end

  // Valid-fetch counter, saturating at all ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= 16'd0;
    end else if (valid && (fetch_cnt != 16'hFFFF)) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

  // Zero-latency fetch; instr_o is forced to zero while reset is held
  assign imem_addr_o = pc;
  assign instr_o     = rst ? imem_rd_i : 16'h0000;
  assign pc_o        = pc;
  assign pc_plus4_o  = pc + PC_STEP;
  assign valid_o     = valid;
  assign halt_o      = (state == HALT);
  assign err_o       = err;
  assign fetch_cnt_o = fetch_cnt;
  assign state_o     = state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, hand-written corner
// sequences and a randomized run checked against a behavioural model.
module tb_pc_fetch_unit;
  import cpu_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]  imem_rd_i;
  logic [15:0]  imem_addr_o;
  logic         stall_i = 1'b0;
  logic         redirect_i = 1'b0;
  logic [15:0]  redirect_pc_i = 16'h0000;
  logic [15:0]  instr_o;
  logic [15:0]  pc_o;
  logic [15:0]  pc_plus4_o;
  logic         valid_o;
  logic         halt_o;
  logic         err_o;
  logic [15:0]  fetch_cnt_o;
  fetch_state_e state_o;

  // Instruction memory covering the full 14-bit word index
  logic [15:0] mem [0:16383];
  assign imem_rd_i = mem[imem_addr_o[15:2]];

  pc_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_rd_i     (imem_rd_i),
    .imem_addr_o   (imem_addr_o),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .valid_o       (valid_o),
    .halt_o        (halt_o),
    .err_o         (err_o),
    .fetch_cnt_o   (fetch_cnt_o),
    .state_o       (state_o)
  );

  // Scoreboard counters
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks: every step starts just after a falling edge
  task automatic drive(input logic s, input logic r, input logic [15:0] rpc);
    stall_i       = s;
    redirect_i    = r;
    redirect_pc_i = rpc;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Directed vector record: inputs for one cycle and outputs expected in it
  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic [15:0] pc;
    logic        valid;
    logic        halt;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [17];

  // Behavioural reference model state
  int m_pc;
  bit m_boot;
  bit m_halt;
  bit m_err;
  int m_cnt;

  task automatic model_reset();
    m_pc = 0; m_boot = 1'b1; m_halt = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  function automatic bit model_valid(input bit s, input bit r);
    return !m_boot && !m_halt && !s && !r;
  endfunction

  task automatic model_step(input bit s, input bit r, input int rpc);
    int w, t;
    bit v;
    v = model_valid(s, r);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halt) begin
      if (r) begin
        m_pc = (rpc / 4) * 4;
        m_halt = 1'b0;
        if (rpc % 4 != 0) m_err = 1'b1;
      end
    end else begin
      if (m_pc / 4 >= 1024) m_err = 1'b1;
      if (r) begin
        m_pc = (rpc / 4) * 4;
        if (rpc % 4 != 0) m_err = 1'b1;
      end else if (!s) begin
        w = int'(mem[m_pc / 4]);
        if (w % 8 == 3) begin
          t = (w / 8) * 4;
          if (t == m_pc) m_halt = 1'b1;
          else m_pc = t;
        end else begin
          m_pc = (m_pc + 4) % 65536;
        end
      end
    end
    if (v && m_cnt < 65535) m_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
    mem[4] = {13'd4, 3'b011};   // self-jump at 0x0010
    mem[7] = 16'h0003;          // jump to 0 at 0x001C

    //           stall redir rpc       pc       valid halt err cnt
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0};   // BOOT
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0008, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 16'h000C, 1'b1, 1'b0, 1'b0, 16'd3};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0010, 1'b1, 1'b0, 1'b0, 16'd4};   // self-jump fetched
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0010, 1'b0, 1'b1, 1'b0, 16'd5};   // HALT
    tbl[7]  = '{1'b0, 1'b1, 16'h0018, 16'h0010, 1'b0, 1'b1, 1'b0, 16'd5};   // redirect out
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0018, 1'b1, 1'b0, 1'b0, 16'd5};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 16'h001C, 1'b1, 1'b0, 1'b0, 16'd6};   // jump 0
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd7};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 1'b0, 1'b0, 16'd8};
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 16'h0008, 1'b0, 1'b0, 1'b0, 16'd9};   // stall 1
    tbl[13] = '{1'b1, 1'b1, 16'h0041, 16'h0008, 1'b0, 1'b0, 1'b0, 16'd9};   // stall 2 + redirect
    tbl[14] = '{1'b1, 1'b0, 16'h0000, 16'h0040, 1'b0, 1'b0, 1'b1, 16'd9};   // stall 3
    tbl[15] = '{1'b0, 1'b0, 16'h0000, 16'h0040, 1'b1, 1'b0, 1'b1, 16'd9};
    tbl[16] = '{1'b0, 1'b0, 16'h0000, 16'h0044, 1'b1, 1'b0, 1'b1, 16'd10};

    // Reset state while rst is held
    @(negedge clk);
    #1;
    check("rst_pc", pc_o, 16'h0000);
    check("rst_pc_plus4", pc_plus4_o, 16'h0004);
    check("rst_valid", 16'(valid_o), 16'd0);
    check("rst_instr", instr_o, 16'h0000);
    do_reset();

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].stall, tbl[i].redir, tbl[i].rpc);
      check($sformatf("tbl%0d_pc", i), pc_o, tbl[i].pc);
      check($sformatf("tbl%0d_addr", i), imem_addr_o, tbl[i].pc);
      check($sformatf("tbl%0d_valid", i), 16'(valid_o), 16'(tbl[i].valid));
      check($sformatf("tbl%0d_halt", i), 16'(halt_o), 16'(tbl[i].halt));
      check($sformatf("tbl%0d_err", i), 16'(err_o), 16'(tbl[i].err));
      check($sformatf("tbl%0d_cnt", i), fetch_cnt_o, tbl[i].cnt);
      if (i == 9) check("jump_instr", instr_o, 16'h0003);
      if (i == 10) check("jump_pc_plus4", pc_plus4_o, 16'h0004);
      next_cycle();
    end

    // Redirect beyond the instruction memory sets err
    do_reset();
    drive(1'b0, 1'b0, 16'h0000); next_cycle();
    drive(1'b0, 1'b1, 16'h1000); next_cycle();
    drive(1'b0, 1'b0, 16'h0000);
    check("range_pc", pc_o, 16'h1000);
    check("range_err_pre", 16'(err_o), 16'd0);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000);
    check("range_err", 16'(err_o), 16'd1);
    next_cycle();

    // Sequential wrap from the top of the address space
    do_reset();
    drive(1'b0, 1'b0, 16'h0000); next_cycle();
    drive(1'b0, 1'b1, 16'hFFFC); next_cycle();
    drive(1'b0, 1'b0, 16'h0000);
    check("wrap_pc_top", pc_o, 16'hFFFC);
    check("wrap_pc_plus4", pc_plus4_o, 16'h0000);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000);
    check("wrap_pc", pc_o, 16'h0000);
    next_cycle();

    // Asynchronous reset between edges, with a redirect and stall in flight
    do_reset();
    drive(1'b0, 1'b0, 16'h0000); next_cycle();
    drive(1'b0, 1'b0, 16'h0000); next_cycle();
    drive(1'b0, 1'b0, 16'h0000); next_cycle();
    drive(1'b0, 1'b1, 16'h0014); next_cycle();
    drive(1'b0, 1'b0, 16'h0000);
    check("mid_pc_pre", pc_o, 16'h0014);
    check("mid_cnt_pre", fetch_cnt_o, 16'd2);
    drive(1'b1, 1'b1, 16'h0083);
    #1 rst = 1'b0;
    #1;
    check("mid_pc", pc_o, 16'h0000);
    check("mid_valid", 16'(valid_o), 16'd0);
    check("mid_cnt", fetch_cnt_o, 16'd0);
    check("mid_err", 16'(err_o), 16'd0);
    check("mid_instr", instr_o, 16'h0000);
    @(negedge clk);
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000);
    check("mid_boot_state", 16'(state_o), 16'(BOOT));
    check("mid_boot_valid", 16'(valid_o), 16'd0);
    check("mid_boot_pc", pc_o, 16'h0000);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000);
    check("mid_run_pc", pc_o, 16'h0000);
    check("mid_run_valid", 16'(valid_o), 16'd1);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000);
    check("mid_run_pc2", pc_o, 16'h0004);
    check("mid_run_err", 16'(err_o), 16'd0);
    next_cycle();

    // Randomized program and control inputs against the reference model
    for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
    for (int k = 0; k < 60; k++) begin
      int a;
      logic [12:0] ja;
      a = $urandom_range(0, 1023);
      ja = 13'(a);
      mem[a] = {ja, 3'b011};
    end
    for (int k = 0; k < 200; k++) begin
      int a;
      a = $urandom_range(0, 1023);
      mem[a] = {3'b000, 10'($urandom_range(0, 1023)), 3'b011};
    end
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bit s, r;
      int rpc;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 11) == 0);
      rpc = $urandom_range(0, 1023) * 4;
      if ($urandom_range(0, 9) == 0) rpc = rpc + $urandom_range(1, 3);
      drive(s, r, 16'(rpc));
      check("rnd_pc", pc_o, 16'(m_pc));
      check("rnd_pc_plus4", pc_plus4_o, 16'((m_pc + 4) % 65536));
      check("rnd_instr", instr_o, mem[m_pc / 4]);
      check("rnd_valid", 16'(valid_o), 16'(model_valid(s, r)));
      check("rnd_halt", 16'(halt_o), 16'(m_halt));
      check("rnd_err", 16'(err_o), 16'(m_err));
      check("rnd_cnt", fetch_cnt_o, 16'(m_cnt));
      model_step(s, r, rpc);
      next_cycle();
    end

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch sequencer that sits directly upstream of the instruction memory.
- Drives the byte address into the instruction memory and receives the combinational 16-bit instruction word back in the same cycle.
- Forwards the instruction with a valid flag to decode.
- Handles the unconditional jump locally; accepts redirects and stalls from later stages and detects a self-loop halt.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- IMEM_WORDS, 1024, instruction memory depth in 16-bit words; used for the range check.
- JUMP_OPC, 3'b011, opcode (instr[2:0]) of the absolute jump.
- HALT_ON_SELF_JUMP, 1, when 1 a jump whose target equals the current PC enters HALT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_rd_i  in  16  instruction word from instruction memory (combinational on imem_addr_o).
- imem_addr_o  out  16  byte address to instruction memory; word index is bits [15:2].
- stall_i  in  1  hold the PC and mark the output not valid.
- redirect_i  in  1  branch/exception redirect from a later stage.
- redirect_pc_i  in  16  redirect target.
- instr_o  out  16  fetched instruction to decode.
- pc_o  out  16  PC of instr_o.
- pc_plus4_o  out  16  pc_o + 4, modulo 2^16.
- valid_o  out  1  instr_o/pc_o are a real fetch this cycle.
- halt_o  out  1  level; core is in HALT.
- err_o  out  1  sticky; misaligned redirect or PC outside IMEM_WORDS.
- fetch_cnt_o  out  16  count of valid fetches, saturating at 16'hFFFF.

Behaviour:
- Reset (rst=0, asynchronous):
  - PC=RESET_PC, state=BOOT.
  - valid_o=0, halt_o=0, err_o=0, fetch_cnt_o=0.
  - instr_o=0, pc_o=RESET_PC, pc_plus4_o=RESET_PC+4.
  - Reset asserted mid-operation discards any in-flight redirect or stall with no residue.
- Addressing: imem_addr_o = PC at all times. instr_o = imem_rd_i and pc_o = PC, combinationally; zero-latency fetch.
- States:
  - BOOT: one cycle after reset release. valid_o=0, PC held. Always goes to RUN; covers the memory's reset-gated output.
  - RUN:
    - valid_o = ~stall_i.
    - PC update priority, highest first:
      1. redirect_i: PC <= {redirect_pc_i[15:2],2'b00}; valid_o=0 this cycle (squash).
      2. stall_i: PC held.
      3. imem_rd_i[2:0]==JUMP_OPC: target = {1'b0, imem_rd_i[15:3], 2'b00}.
         - If HALT_ON_SELF_JUMP and target==PC: go to HALT, PC held.
         - Otherwise PC <= target.
      4. Otherwise PC <= PC+4, wrapping 16'hFFFC -> 16'h0000 with no flag.
  - HALT: valid_o=0, halt_o=1, PC frozen. redirect_i returns to RUN with the redirect PC. Only rst or redirect_i exits.
- err_o (sticky, cleared only by rst), set on either:
  - redirect_i with redirect_pc_i[1:0] != 0; low bits are still forced to 0.
  - PC[15:2] >= IMEM_WORDS while in RUN.
- fetch_cnt_o: +1 on every cycle with valid_o=1; holds at 16'hFFFF.
- Simultaneous events:
  - redirect_i+stall_i: redirect wins and is not lost.
  - Jump fetched while stall_i=1: not taken until the stall clears; it is re-evaluated on the unstalled cycle.
- All state registers are on the clk rising edge with the async active-low rst clear; the outputs listed above are combinational from state/PC.

Decomposition:
- Shared package (cpu_pkg):
  - ISA constants: opcode width 3, JUMP_OPC, instruction field positions (fun[15:12], rd[11:9], rt[8:6], rs[5:3], op[2:0], jaddr[15:3]).
  - Fetch state encoding: BOOT=2'd0, RUN=2'd1, HALT=2'd2.
  - PC_STEP=4.
- One sub-module is natural: next_pc_sel. A purely combinational priority mux computing next PC, the halt request, and the misalignment flag. The parent holds the registers, FSM and counter.

Test Plan:
- Release reset with a program of 4 non-jump words. Required:
  - BOOT cycle with valid_o=0.
  - Then pc_o = 0, 4, 8, 12 on consecutive cycles with valid_o=1.
  - fetch_cnt_o=4 after 4 valid cycles.
- Word at PC 0x001C = 16'h0003 (jump 0). Required: next pc_o=0x0000; at pc 0x0000, pc_plus4_o=0x0004.
- Word at PC 0x0010 = {13'd4,3'b011} (self-jump). Required: halt_o=1 the next cycle, valid_o=0, pc_o stays 0x0010. A later redirect_i with 0x0020 gives pc_o=0x0020 and halt_o=0.
- stall_i=1 for 3 cycles at PC 0x0008, with redirect_i=1 (0x0041) on the 2nd stall cycle. Required:
  - valid_o=0 throughout.
  - PC becomes 0x0040.
  - err_o=1 and stays set.
- PC forced to 0x1000 (word 1024) via redirect. Required: err_o=1. Separately, redirect to 0xFFFC followed by a plain instruction wraps pc_o to 0x0000.
- Drop rst mid-stream at PC 0x0014 between clock edges. Required: immediately pc_o=RESET_PC, valid_o=0, fetch_cnt_o=0, err_o=0, then a BOOT cycle after release.
